io_stream_port: RTL
===================

Name: io_stream_port

Overview:
- Memory-mapped I/O peripheral on the CPU's I/O address space; replaces the ad-hoc debug output/input logic.
- Buffers CPU writes into a TX FIFO and drains it over a valid/ready output stream.
- Buffers an external valid/ready input stream into an RX FIFO for CPU reads.
- Adds status/control registers, sticky error flags, a level interrupt and an internal loopback mode.

Parameters:
- DATA_W, 8, data bus and stream width
- ADDR_W, 8, I/O address width
- BASE_ADDR, 8'h00, address of offset 0; full-compare decode
- TX_DEPTH, 8, TX FIFO entries; power of two, >=2, <= 2**DATA_W-1
- RX_DEPTH, 8, RX FIFO entries; same constraints as TX_DEPTH

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- io_sel  in  1  I/O space selected (CPU mem_io)
- io_stb  in  1  access strobe (CPU mem_clk phase)
- io_we  in  1  write access
- io_oe  in  1  read access
- io_addr  in  ADDR_W  I/O address
- io_wdata  in  DATA_W  CPU write data
- io_rdata  out  DATA_W  read data; top level tristates it onto bus with io_drive
- io_drive  out  1  drive enable for the shared bus
- tx_data  out  DATA_W  output stream data
- tx_valid  out  1  output stream valid
- tx_ready  in  1  output stream ready
- rx_data  in  DATA_W  input stream data
- rx_valid  in  1  input stream valid
- rx_ready  out  1  input stream ready
- irq  out  1  level interrupt, registered
- bad_access  out  1  one-cycle pulse on access to an unmapped address

Behaviour:
- Access: acc = io_sel & io_stb & (io_we | io_oe). Side effects commit on the clk rise while acc=1. One access per cycle; io_we and io_oe both high is treated as a write.
- Register map, offsets from BASE_ADDR:
  - 0 TXDATA: write pushes to TX FIFO; reads as 0.
  - 1 RXDATA: read returns the RX head (FWFT) and pops it.
  - 2 STATUS, read: b0 tx_full, b1 tx_empty, b2 rx_full, b3 rx_empty, b4 tx_ovf, b5 rx_unf, b6 loop, others 0. Write with b4/b5 set clears the corresponding sticky flag (W1C).
  - 3 CTRL, R/W: b0 rx_ie, b1 tx_ie, b2 loop.
  - 4 TXCNT, read-only: TX occupancy, zero-extended.
  - 5 RXCNT, read-only: RX occupancy, zero-extended.
- Reads are combinational from io_addr. io_drive = acc & io_oe & ~io_we & mapped. Unmapped or write cycles: io_drive=0, io_rdata=0.
- Unmapped address: writes ignored; bad_access=1 for the following cycle only.
- Write to a full TX FIFO: data dropped, tx_ovf set.
- Read of an empty RX FIFO: returns 0, no pop, rx_unf set. A set and a W1C clear in the same cycle: set wins.
- Normal mode (loop=0):
  - tx_valid = ~tx_empty; tx_data = TX head; pop when tx_valid & tx_ready.
  - rx_ready = ~rx_full; push when rx_valid & rx_ready.
  - No combinational path from tx_ready to tx_valid, or from rx_valid to rx_ready.
- Loop mode (loop=1):
  - tx_valid=0 and rx_ready=0.
  - One word per cycle moves TX head -> RX tail when ~tx_empty & ~rx_full.
- FIFOs:
  - Simultaneous push and pop when full: both occur, count unchanged.
  - Simultaneous push and pop when empty: push only.
  - Pointers wrap modulo depth. Count width is clog2(DEPTH+1).
- irq is registered: next = (rx_ie & ~rx_empty) | (tx_ie & tx_empty) | tx_ovf | rx_unf.
- Reset values: FIFOs empty, pointers 0, CTRL=0, sticky flags 0, irq=0, bad_access=0, tx_valid=0, rx_ready=1 (RX empty, loop=0), io_drive=0, io_rdata=0. Reset mid-transfer discards all FIFO contents; no partial word survives.
- Latency:
  - CPU write -> tx_valid: 1 cycle.
  - Input-stream push -> readable at RXDATA: next cycle.
  - Loop transfer: 1 cycle TX -> RX.

Decomposition:
- Shared package holds:
  - register offsets OFF_TXDATA..OFF_RXCNT
  - STATUS bit indices
  - CTRL bit indices
- One sub-module, sync_fifo, instantiated twice:
  - parameters DATA_W and DEPTH
  - FWFT read, full/empty/count outputs
  - async active-high reset

Test Plan:
- Reset, then CPU writes 8'h2A to offset 0 with tx_ready=1 -> tx_valid rises next cycle with tx_data=8'h2A; pops; TXCNT reads 0.
- tx_ready=0, write 9 words 1..9 (TX_DEPTH=8) -> TXCNT=8, STATUS b0=1, b4=1. Write 8'h10 to STATUS -> b4 clears. Raise tx_ready -> 1..8 emerge in order.
- rx stream sends 8'h55, 8'hAA -> reads of offset 1 return 55 then AA with io_drive=1. Third read returns 0, sets rx_unf, irq=1 next cycle.
- CTRL=8'h04 (loop), write 3,4,5 -> tx_valid stays 0, rx_ready=0; RXCNT reaches 3; reads return 3,4,5.
- Read offset 7 -> io_drive=0, io_rdata=0, bad_access pulses for one cycle; no state change.
- Assert reset with 5 words in TX and CTRL=8'h03 -> all outputs at reset values immediately (async); TXCNT=0 after release.

Source files
------------

// File: rtl/io_stream_port_pkg.sv
// Shared definitions for the I/O stream port: register offsets and bit positions.
package io_stream_port_pkg;

   localparam int unsigned NUM_REGS = 6;

   localparam logic [2:0] OFF_TXDATA = 3'd0;
   localparam logic [2:0] OFF_RXDATA = 3'd1;
   localparam logic [2:0] OFF_STATUS = 3'd2;
   localparam logic [2:0] OFF_CTRL   = 3'd3;
   localparam logic [2:0] OFF_TXCNT  = 3'd4;
   localparam logic [2:0] OFF_RXCNT  = 3'd5;

   localparam int unsigned ST_TX_FULL  = 0;
   localparam int unsigned ST_TX_EMPTY = 1;
   localparam int unsigned ST_RX_FULL  = 2;
   localparam int unsigned ST_RX_EMPTY = 3;
   localparam int unsigned ST_TX_OVF   = 4;
   localparam int unsigned ST_RX_UNF   = 5;
   localparam int unsigned ST_LOOP     = 6;

   localparam int unsigned CTRL_RX_IE = 0;
   localparam int unsigned CTRL_TX_IE = 1;
   localparam int unsigned CTRL_LOOP  = 2;
   localparam int unsigned CTRL_W     = 3;

endpackage

// File: rtl/io_stream_port_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// A pop on an empty FIFO is ignored; a push on a full FIFO only lands when a pop frees the slot in the same cycle.
module sync_fifo #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 8,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data,
   output logic              full,
   output logic              empty,
   output logic [CNT_W-1:0]  count
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              push_ok;
   logic              pop_ok;

   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

   // Next-state for storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
   always_comb begin
      pop_ok   = pop & ~empty;
      push_ok  = push & (~full | pop_ok);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // State registers; reset clears contents so nothing from before reset can reappear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/io_stream_port.sv
// Memory-mapped I/O port: CPU writes feed a TX stream, an RX stream feeds CPU reads,
// with status/control registers, sticky error flags, a level interrupt and internal loopback.
module io_stream_port
   import io_stream_port_pkg::*;
#(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int unsigned TX_DEPTH = 8,
   parameter int unsigned RX_DEPTH = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              io_sel,
   input  logic              io_stb,
   input  logic              io_we,
   input  logic              io_oe,
   input  logic [ADDR_W-1:0] io_addr,
   input  logic [DATA_W-1:0] io_wdata,
   output logic [DATA_W-1:0] io_rdata,
   output logic              io_drive,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              irq,
   output logic              bad_access
);

   localparam int unsigned TX_CNT_W = $clog2(TX_DEPTH + 1);
   localparam int unsigned RX_CNT_W = $clog2(RX_DEPTH + 1);

   logic              acc, wr_acc, rd_acc;
   logic [ADDR_W-1:0] off;
   logic              mapped;
   logic [2:0]        reg_idx;
   logic              hit_txdata, hit_rxdata, hit_status, hit_ctrl;

   logic              tx_push, tx_pop, tx_full, tx_empty;
   logic [DATA_W-1:0] tx_head;
   logic [TX_CNT_W-1:0] tx_count;
   logic              rx_push, rx_pop, rx_full, rx_empty;
   logic [DATA_W-1:0] rx_head, rx_push_data;
   logic [RX_CNT_W-1:0] rx_count;

   logic              loop_en, loop_move;
   logic              tx_ovf_set, rx_unf_set;
   logic [DATA_W-1:0] rdata_mux;

   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic              tx_ovf_q, tx_ovf_d;
   logic              rx_unf_q, rx_unf_d;
   logic              irq_q, irq_d;
   logic              bad_access_q, bad_access_d;

   // Upper write-data bits have no register behind them.
   logic              unused_wdata;
   assign unused_wdata = ^io_wdata;

   // Address decode relative to BASE_ADDR; both strobes high counts as a write.
   always_comb begin
      acc        = io_sel & io_stb & (io_we | io_oe);
      wr_acc     = acc & io_we;
      rd_acc     = acc & io_oe & ~io_we;
      off        = io_addr - BASE_ADDR;
      mapped     = (off < ADDR_W'(NUM_REGS));
      reg_idx    = off[2:0];
      hit_txdata = mapped & (reg_idx == OFF_TXDATA);
      hit_rxdata = mapped & (reg_idx == OFF_RXDATA);
      hit_status = mapped & (reg_idx == OFF_STATUS);
      hit_ctrl   = mapped & (reg_idx == OFF_CTRL);
   end

   // Stream handshakes and FIFO steering; in loopback the TX head moves straight into RX.
   always_comb begin
      loop_en      = ctrl_q[CTRL_LOOP];
      loop_move    = loop_en & ~tx_empty & ~rx_full;
      tx_valid     = ~loop_en & ~tx_empty;
      rx_ready     = ~loop_en & ~rx_full;
      tx_data      = tx_head;
      tx_push      = wr_acc & hit_txdata;
      tx_pop       = loop_en ? loop_move : (tx_valid & tx_ready);
      rx_push      = loop_en ? loop_move : (rx_valid & rx_ready);
      rx_push_data = loop_en ? tx_head : rx_data;
      rx_pop       = rd_acc & hit_rxdata & ~rx_empty;
      tx_ovf_set   = tx_push & tx_full & ~tx_pop;
      rx_unf_set   = rd_acc & hit_rxdata & rx_empty;
   end

   sync_fifo #(.DATA_W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (tx_push),
      .push_data (io_wdata),
      .pop       (tx_pop),
      .pop_data  (tx_head),
      .full      (tx_full),
      .empty     (tx_empty),
      .count     (tx_count)
   );

   sync_fifo #(.DATA_W(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (rx_push),
      .push_data (rx_push_data),
      .pop       (rx_pop),
      .pop_data  (rx_head),
      .full      (rx_full),
      .empty     (rx_empty),
      .count     (rx_count)
   );

   // Control/sticky next state; a new error beats a same-cycle W1C. The interrupt sees fresh
   // control and sticky values, while FIFO levels contribute as of this cycle.
   always_comb begin
      ctrl_d = ctrl_q;
      if (wr_acc & hit_ctrl) begin
         ctrl_d = io_wdata[CTRL_W-1:0];
      end
      tx_ovf_d = tx_ovf_q;
      rx_unf_d = rx_unf_q;
      if (wr_acc & hit_status & io_wdata[ST_TX_OVF]) begin
         tx_ovf_d = 1'b0;
      end
      if (wr_acc & hit_status & io_wdata[ST_RX_UNF]) begin
         rx_unf_d = 1'b0;
      end
      if (tx_ovf_set) begin
         tx_ovf_d = 1'b1;
      end
      if (rx_unf_set) begin
         rx_unf_d = 1'b1;
      end
      bad_access_d = acc & ~mapped;
      irq_d = (ctrl_d[CTRL_RX_IE] & ~rx_empty) | (ctrl_d[CTRL_TX_IE] & tx_empty) | tx_ovf_d | rx_unf_d;
   end

   // Register file state and registered irq/bad_access outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_q       <= '0;
         tx_ovf_q     <= 1'b0;
         rx_unf_q     <= 1'b0;
         irq_q        <= 1'b0;
         bad_access_q <= 1'b0;
      end else begin
         ctrl_q       <= ctrl_d;
         tx_ovf_q     <= tx_ovf_d;
         rx_unf_q     <= rx_unf_d;
         irq_q        <= irq_d;
         bad_access_q <= bad_access_d;
      end
   end

   assign irq        = irq_q;
   assign bad_access = bad_access_q;

   // Combinational read mux; the bus is released during reset even if a read is in progress.
   always_comb begin
      rdata_mux = '0;
      case (reg_idx)
         OFF_RXDATA: rdata_mux = rx_head;
         OFF_STATUS: begin
            rdata_mux[ST_TX_FULL]  = tx_full;
            rdata_mux[ST_TX_EMPTY] = tx_empty;
            rdata_mux[ST_RX_FULL]  = rx_full;
            rdata_mux[ST_RX_EMPTY] = rx_empty;
            rdata_mux[ST_TX_OVF]   = tx_ovf_q;
            rdata_mux[ST_RX_UNF]   = rx_unf_q;
            rdata_mux[ST_LOOP]     = ctrl_q[CTRL_LOOP];
         end
         OFF_CTRL:   rdata_mux[CTRL_W-1:0] = ctrl_q;
         OFF_TXCNT:  rdata_mux[TX_CNT_W-1:0] = tx_count;
         OFF_RXCNT:  rdata_mux[RX_CNT_W-1:0] = rx_count;
         default:    rdata_mux = '0;
      endcase
      io_drive = rd_acc & mapped & ~reset;
      io_rdata = io_drive ? rdata_mux : '0;
   end

endmodule
